// File: rtl/pixel_receiver.sv
// One-wire pixel stream decoder: pulse-width bit decode, 24-bit pixel handshake, frame latch detect.
// Optional cascade passthrough on dout when PIXEL_RX_PASSTHRU_EN is defined.
module pixel_receiver #(
    parameter int BIT_THRESH   = 10,
    parameter int MIN_HIGH     = 3,
    parameter int MAX_HIGH     = 30,
    parameter int LATCH_CYCLES = 800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] color,
    output logic        valid,
    input  logic        ready,
    output logic        frame_end,
    output logic [8:0]  px_count,
    output logic        overflow,
    output logic        err,
    output logic        dout
);

    localparam int CNT_MAX = (LATCH_CYCLES > MAX_HIGH) ? LATCH_CYCLES : MAX_HIGH;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // The counter is cleared on state entry, so it holds (elapsed cycles - 1) at each decision.
    localparam logic [CW-1:0] K_MIN   = CW'(MIN_HIGH - 1);
    localparam logic [CW-1:0] K_BIT   = CW'(BIT_THRESH - 1);
    localparam logic [CW-1:0] K_ERR   = CW'(MAX_HIGH - 1);
    localparam logic [CW-1:0] K_LATCH = CW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;

    logic          r_sync1;
    logic          r_s;
    logic          r_s_d;
    logic          w_rise;

    logic          w_bit_en;
    logic          w_bit_val;
    logic          w_latch;
    logic          w_hi_err;

    logic [4:0]    r_bitcnt;
    logic [22:0]   r_shift;
    logic [23:0]   w_pixel;
    logic          w_last;
    logic          w_pixel_done;
    logic          w_load;

    logic [23:0]   r_color;
    logic          r_valid;
    logic          r_frame_end;
    logic [8:0]    r_px_count;
    logic          r_overflow;
    logic          r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_s_d   <= 1'b0;
        end else begin
            r_sync1 <= din;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
        end
    end

    assign w_rise = r_s & ~r_s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_en     = 1'b0;
        w_bit_val    = 1'b0;
        w_latch      = 1'b0;
        w_hi_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end
            end
            S_HIGH: begin
                if (r_cnt >= K_ERR) begin
                    w_hi_err     = 1'b1;
                    w_state_next = S_ERR;
                    w_cnt_next   = '0;
                end else if (!r_s) begin
                    w_state_next = S_LOW;
                    w_cnt_next   = '0;
                    if (r_cnt >= K_MIN) begin
                        w_bit_en  = 1'b1;
                        w_bit_val = (r_cnt >= K_BIT);
                    end
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_LOW: begin
                if (r_s) begin
                    w_state_next = S_HIGH;
                    w_cnt_next   = '0;
                end else if (r_cnt >= K_LATCH) begin
                    w_latch      = 1'b1;
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_ERR: begin
                if (r_s) begin
                    w_cnt_next = '0;
                end else if (r_cnt >= K_LATCH) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_pixel      = {r_shift, w_bit_val};
    assign w_last       = (r_bitcnt == 5'd23);
    assign w_pixel_done = w_bit_en & w_last;
    assign w_load       = w_pixel_done & (~r_valid | ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_color     <= '0;
            r_valid     <= 1'b0;
            r_frame_end <= 1'b0;
            r_px_count  <= '0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_frame_end <= w_latch;
            r_err       <= w_hi_err | (w_latch & (r_bitcnt != 5'd0));
            r_overflow  <= w_pixel_done & ~w_load;

            if (w_latch || w_hi_err) begin
                r_bitcnt <= '0;
            end else if (w_bit_en) begin
                r_bitcnt <= w_last ? 5'd0 : r_bitcnt + 5'd1;
            end

            if (w_bit_en) begin
                r_shift <= w_pixel[22:0];
            end

            // A fresh load wins over a same-cycle handshake so valid stays up with the new pixel.
            if (w_load) begin
                r_color <= w_pixel;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end

            if (w_latch) begin
                r_px_count <= '0;
            end else if (w_pixel_done && r_px_count != 9'd511) begin
                r_px_count <= r_px_count + 9'd1;
            end
        end
    end

    assign color     = r_color;
    assign valid     = r_valid;
    assign frame_end = r_frame_end;
    assign px_count  = r_px_count;
    assign overflow  = r_overflow;
    assign err       = r_err;

`ifdef PIXEL_RX_PASSTHRU_EN
    logic r_pass;
    logic r_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
            r_dout <= 1'b0;
        end else begin
            if (w_latch) begin
                r_pass <= 1'b0;
            end else if (w_pixel_done) begin
                r_pass <= 1'b1;
            end
            r_dout <= r_pass & r_s;
        end
    end

    assign dout = r_dout;
`else
    assign dout = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_receiver.sv
// Directed bench for pixel_receiver: scoreboard of expected pixels popped on each valid/ready handshake.
module tb_pixel_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic        ready;
    logic [23:0] color;
    logic        valid;
    logic        frame_end;
    logic [8:0]  px_count;
    logic        overflow;
    logic        err;
    logic        dout;

    pixel_receiver #(
        .BIT_THRESH  (10),
        .MIN_HIGH    (3),
        .MAX_HIGH    (30),
        .LATCH_CYCLES(800)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .color    (color),
        .valid    (valid),
        .ready    (ready),
        .frame_end(frame_end),
        .px_count (px_count),
        .overflow (overflow),
        .err      (err),
        .dout     (dout)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    int          n_hs   = 0;
    int          n_fe   = 0;
    int          n_err  = 0;
    int          n_ovf  = 0;
    int          n_both = 0;
    int          dmode  = 0;
    logic [3:0]  hist   = '0;
    int          err_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pixel scoreboard, pulse counters and dout cascade checks.
    always @(negedge clk) begin
        if (valid && ready) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                check("pixel", 32'(color), 32'(exp_q.pop_front()));
            end
            n_hs++;
        end
        if (frame_end) n_fe++;
        if (err) n_err++;
        if (overflow) n_ovf++;
        if (frame_end && err) n_both++;
        hist = {hist[2:0], din};
        if (dmode == 1) begin
            check("dout_low", 32'(dout), 32'd0);
        end else if (dmode == 2) begin
            check("dout_mirror", 32'(dout), 32'(hist[3]));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        din = 1'b1;
        tick(b ? 13 : 6);
        din = 1'b0;
        tick(b ? 7 : 14);
    endtask

    task automatic send_bits(input logic [23:0] p, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(p[i]);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        send_bits(p, 23, 0);
    endtask

    initial begin
        rst   = 1'b1;
        din   = 1'b0;
        ready = 1'b1;
        tick(3);
        check("rst_color", 32'(color), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_px_count", 32'(px_count), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        rst = 1'b0;
        tick(5);

        // Three pixels with ready high, latency measured on the first.
        exp_q.push_back(24'hFF0000);
        exp_q.push_back(24'h00FF00);
        exp_q.push_back(24'h0000FF);
        send_bits(24'hFF0000, 23, 1);
        din = 1'b1;
        tick(6);
        din = 1'b0;
        tick(2);
        check("latency_2clk", 32'(valid), 32'd0);
        tick(1);
        check("latency_3clk", 32'(valid), 32'd1);
        tick(11);
        send_pixel(24'h00FF00);
        send_pixel(24'h0000FF);
        tick(10);
        check("t1_px_count", 32'(px_count), 32'd3);
        check("t1_handshakes", 32'(n_hs), 32'd3);
        check("t1_no_early_fe", 32'(n_fe), 32'd0);
        tick(900);
        check("t1_frame_end", 32'(n_fe), 32'd1);
        check("t1_err", 32'(n_err), 32'd0);
        check("t1_px_cleared", 32'(px_count), 32'd0);
        check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

        // Same stream with sink stalled: first pixel held, two drops.
        ready = 1'b0;
        exp_q.push_back(24'hFF0000);
        send_pixel(24'hFF0000);
        send_pixel(24'h00FF00);
        send_pixel(24'h0000FF);
        tick(10);
        check("t2_color_held", 32'(color), 32'hFF0000);
        check("t2_valid", 32'(valid), 32'd1);
        check("t2_overflow", 32'(n_ovf), 32'd2);
        check("t2_px_count", 32'(px_count), 32'd3);
        ready = 1'b1;
        tick(1);
        check("t2_handshake", 32'(n_hs), 32'd4);
        check("t2_valid_clear", 32'(valid), 32'd0);
        tick(900);
        check("t2_frame_end", 32'(n_fe), 32'd2);

        // Short glitch between bits must be ignored.
        exp_q.push_back(24'hA5A5A5);
        send_bits(24'hA5A5A5, 23, 16);
        din = 1'b1;
        tick(2);
        din = 1'b0;
        tick(8);
        send_bits(24'hA5A5A5, 15, 0);
        tick(10);
        check("t3_handshake", 32'(n_hs), 32'd5);
        check("t3_color", 32'(color), 32'hA5A5A5);
        check("t3_no_err", 32'(n_err), 32'd0);
        tick(900);
        check("t3_frame_end", 32'(n_fe), 32'd3);

        // Stuck-high line: err at the 30-cycle limit (plus sync and register delay).
        din    = 1'b1;
        err_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (err && err_at == 0) err_at = i;
        end
        check("t4_err_time", 32'(err_at), 32'd33);
        check("t4_err_count", 32'(n_err), 32'd1);
        din = 1'b0;
        tick(100);
        send_pixel(24'h111111);
        tick(900);
        check("t4_no_valid_in_err", 32'(n_hs), 32'd5);
        check("t4_no_fe_on_exit", 32'(n_fe), 32'd3);
        exp_q.push_back(24'h123123);
        send_pixel(24'h123123);
        tick(10);
        check("t4_recovered", 32'(n_hs), 32'd6);
        tick(900);
        check("t4_frame_end", 32'(n_fe), 32'd4);

        // Latch after a partial pixel: frame_end with err, then a clean pixel.
        send_bits(24'hABCDEF, 23, 12);
        tick(900);
        check("t5_frame_end", 32'(n_fe), 32'd5);
        check("t5_err", 32'(n_err), 32'd2);
        check("t5_same_cycle", 32'(n_both), 32'd1);
        check("t5_no_valid", 32'(n_hs), 32'd6);
        exp_q.push_back(24'h123456);
        send_pixel(24'h123456);
        tick(10);
        check("t5_handshake", 32'(n_hs), 32'd7);
        check("t5_color", 32'(color), 32'h123456);
        tick(900);
        check("t5_frame_end2", 32'(n_fe), 32'd6);
        check("t5_err_unchanged", 32'(n_err), 32'd2);

        // Reset mid-pixel, then two pixels with cascade checks.
        send_bits(24'hFFFFFF, 23, 14);
        rst = 1'b1;
        tick(2);
        check("t6_rst_px_count", 32'(px_count), 32'd0);
        check("t6_rst_color", 32'(color), 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        tick(5);
        exp_q.push_back(24'hC0FFEE);
        exp_q.push_back(24'h5A5A5A);
        dmode = 1;
        send_pixel(24'hC0FFEE);
`ifdef PIXEL_RX_PASSTHRU_EN
        dmode = 2;
`endif
        send_pixel(24'h5A5A5A);
        tick(10);
        dmode = 0;
        check("t6_handshakes", 32'(n_hs), 32'd9);
        check("t6_px_count", 32'(px_count), 32'd2);
        tick(900);
        check("t6_frame_end", 32'(n_fe), 32'd7);
        check("t6_dout_after_fe", 32'(dout), 32'd0);
        check("final_sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_receiver.md
PIXEL_RECEIVER -- requirements
Module: pixel_receiver

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 10, meaning high-time in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MIN_HIGH, default 3, meaning high pulses shorter than this many cycles are glitches.
REQ-003 SHALL have parameter MAX_HIGH, default 30, meaning high-time at or above which the line is in error.
REQ-004 SHALL have parameter LATCH_CYCLES, default 800, meaning line-low cycles that end a frame (50 us at 16 MHz).
REQ-005 SHALL have port clk, input, 1 bit, the single clock, 16 MHz.
REQ-006 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port din, input, 1 bit, asynchronous one-wire pixel stream.
REQ-008 SHALL have port color, output, 24 bits, decoded pixel; the first wire bit is color[23].
REQ-009 SHALL have port valid, output, 1 bit, color holds an unconsumed pixel.
REQ-010 SHALL have port ready, input, 1 bit, sink accepts color when valid and ready are both high.
REQ-011 SHALL have port frame_end, output, 1 bit, one-cycle pulse on latch detect.
REQ-012 SHALL have port px_count, output, 9 bits, pixels decoded in the current frame.
REQ-013 SHALL have port overflow, output, 1 bit, one-cycle pulse when a pixel is dropped.
REQ-014 SHALL have port err, output, 1 bit, one-cycle pulse on a protocol error.
REQ-015 SHALL have port dout, output, 1 bit, cascade output (see Configuration).

Function
REQ-016 SHALL pass din through a two-flop synchronizer; all decoding uses the synchronized value s.
REQ-017 SHALL implement states IDLE, HIGH, LOW and ERR.
REQ-018 IDLE: on a rising edge of s, go to HIGH with the high counter cleared.
REQ-019 HIGH: count cycles; at a falling edge with count < MIN_HIGH, go to LOW with no bit recorded; otherwise shift in bit (count >= BIT_THRESH) MSB-first and go to LOW.
REQ-020 HIGH: when count reaches MAX_HIGH, pulse err, clear the bit counter, and go to ERR.
REQ-021 LOW: count cycles; a rising edge goes to HIGH; when count reaches LATCH_CYCLES, pulse frame_end, clear px_count and the bit counter, and go to IDLE.
REQ-022 A latch with the bit counter nonzero SHALL discard the partial bits and pulse err together with frame_end.
REQ-023 ERR: wait for s low for LATCH_CYCLES consecutive cycles, then go to IDLE with no frame_end.
REQ-024 On the 24th bit, if valid=0 or ready=1 in that cycle, SHALL load color, set valid the next cycle, and increment px_count.
REQ-025 If valid=1 and ready=0 when the 24th bit completes, SHALL keep the old color, pulse overflow, and still increment px_count.
REQ-026 valid SHALL clear the cycle after valid and ready are both high, unless a new pixel loads in that same cycle (then valid stays high with the new color).
REQ-027 Latency SHALL be 3 clk from the din falling edge of bit 24 to valid high.
REQ-028 px_count SHALL saturate at 511.
REQ-029 Counters SHALL be wide enough for LATCH_CYCLES without wrap.

Reset
REQ-030 rst SHALL asynchronously force IDLE, clear the synchronizer, counters, shift register, color=0, valid=0, frame_end=0, overflow=0, err=0, px_count=0 and dout=0.
REQ-031 Reset mid-pixel SHALL discard partial bits; after release, decoding resumes only from the next rising edge of s.

Configuration
REQ-032 With macro PIXEL_RX_PASSTHRU_EN defined, dout SHALL be held low while the first pixel of a frame is received, and SHALL equal s delayed one clk for the rest of the frame, until frame_end.
REQ-033 Without PIXEL_RX_PASSTHRU_EN, dout SHALL be tied to 0 and no passthrough logic SHALL be built.

Verification
REQ-034 Three pixels FF0000, 00FF00, 0000FF (high 13 cycles for a 1 bit, 6 for a 0, 20-cycle period) then 900 cycles low, ready=1 -> three valid pulses with those colors, px_count=3, then one frame_end pulse.
REQ-035 Same stream with ready=0 throughout -> color=FF0000 held, valid high, two overflow pulses, px_count=3.
REQ-036 A 2-cycle high glitch between bits of pixel A5A5A5 -> color=A5A5A5 and no err.
REQ-037 din high for 40 cycles -> err pulses at cycle 30 of high; no valid until after 800 low cycles and a fresh pixel.
REQ-038 Latch after 12 bits -> frame_end and err in the same cycle, no valid; next full pixel 123456 decodes correctly.
REQ-039 rst asserted after 10 bits, then a full pixel C0FFEE -> color=C0FFEE; with PIXEL_RX_PASSTHRU_EN defined, dout stays low during pixel 1 and mirrors din during pixel 2.
